// File: rtl/sudoku_grid_checker.sv
// sudoku_grid_checker
//   Holds an N x N sudoku grid (N = BOX_W*BOX_W) loaded row-major over a
//   valid/ready write stream, then on start scans every row, every column and
//   every box, one cell per clock, and reports whether any unit breaks the
//   "each value 1..N at most once" rule. Only the first violating unit is
//   reported.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     clr               synchronous clear of grid, write pointer, flags, scan
//     wr_valid/wr_data  next cell value, row-major; accepted when wr_ready
//     wr_ready          writes accepted (idle, no scan in flight)
//     grid_full         sticky: last cell written since clr/reset
//     start             begin a scan (ignored unless idle)
//     busy              scan in progress
//     done              sticky: last scan completed
//     err               sticky: last scan found a violation
//     err_kind          first violation: 0 none, 1 row, 2 column, 3 box
//     err_unit          index of first violating unit (boxes row-major)
//
//   The grid is read through a one-cycle fetch register, so the checker runs
//   one clock behind the address counters. That is why busy rises one edge
//   after start is taken and done rises one edge after the counters finish.

module sudoku_grid_checker #(
  parameter int BOX_W       = 3,
  parameter int ALLOW_EMPTY = 1,
  parameter int VAL_W       = $clog2(BOX_W * BOX_W + 1),
  parameter int IDX_W       = $clog2(BOX_W * BOX_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_valid,
  input  logic [VAL_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             grid_full,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_kind,
  output logic [IDX_W-1:0] err_unit
);

  localparam int N      = BOX_W * BOX_W;
  localparam int CELLS  = N * N;
  localparam int ADDR_W = $clog2(CELLS);

  // Scan-state encoding doubles as the err_kind code of the unit being scanned.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROWS  = 2'd1,
    S_COLS  = 2'd2,
    S_BOXES = 2'd3
  } state_t;

  state_t            state;
  logic [VAL_W-1:0]  grid [CELLS];
  logic [ADDR_W-1:0] wr_ptr;
  logic [IDX_W-1:0]  unit_cnt;
  logic [IDX_W-1:0]  cell_cnt;
  logic [ADDR_W-1:0] rd_addr;

  // Fetch stage: one grid cell plus the context needed to judge it.
  logic              p_valid;
  logic              p_first;
  logic              p_last;
  logic [VAL_W-1:0]  p_val;
  logic [1:0]        p_kind;
  logic [IDX_W-1:0]  p_unit;

  logic [N-1:0]      seen;
  logic [N-1:0]      seen_base;
  logic [N-1:0]      seen_next;
  logic [N-1:0]      val_bit;
  logic              cell_bad;

  logic              wr_fire;
  logic              start_fire;
  logic              unit_end;
  logic              unit_last;

  // Idle means the counters are parked and the fetch stage has drained.
  assign wr_ready   = (state == S_IDLE) && !busy;
  assign wr_fire    = wr_valid && wr_ready;
  assign start_fire = start && wr_ready;
  assign unit_end   = (cell_cnt == IDX_W'(N - 1));
  assign unit_last  = (unit_cnt == IDX_W'(N - 1));

  // Map (unit, cell-within-unit) to a row-major grid address.
  always_comb begin
    int u_i, k_i, row_i, col_i;
    u_i   = int'(unit_cnt);
    k_i   = int'(cell_cnt);
    row_i = u_i;
    col_i = k_i;
    case (state)
      S_COLS: begin
        row_i = k_i;
        col_i = u_i;
      end
      S_BOXES: begin
        row_i = (u_i / BOX_W) * BOX_W + k_i / BOX_W;
        col_i = (u_i % BOX_W) * BOX_W + k_i % BOX_W;
      end
      default: ;
    endcase
    rd_addr = ADDR_W'(row_i * N + col_i);
  end

  // Judge the fetched cell against the unit's seen mask.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    seen_base = p_first ? '0 : seen;
    seen_next = seen_base;
    val_bit   = '0;
    cell_bad  = 1'b0;
    if (p_val == '0) begin
      cell_bad = (ALLOW_EMPTY == 0);
    end else if (int'(p_val) > N) begin
      cell_bad = 1'b1;
    end else begin
      val_bit   = N'(1) << (p_val - VAL_W'(1));
      cell_bad  = |(seen_base & val_bit);
      seen_next = seen_base | val_bit;
    end
  end

  // NOTE: all state below updates with <= so every read in this block sees
  // the pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the grid array is reset on purpose: after reset the board must
      // read as all-empty, so this storage is built from resettable flops.
      for (int i = 0; i < CELLS; i++) grid[i] <= '0;
      state     <= S_IDLE;
      wr_ptr    <= '0;
      grid_full <= 1'b0;
      unit_cnt  <= '0;
      cell_cnt  <= '0;
      p_valid   <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      p_val     <= '0;
      p_kind    <= '0;
      p_unit    <= '0;
      seen      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_kind  <= '0;
      err_unit  <= '0;
    end else if (clr) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= '0;
      state     <= S_IDLE;
      wr_ptr    <= '0;
      grid_full <= 1'b0;
      unit_cnt  <= '0;
      cell_cnt  <= '0;
      p_valid   <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      seen      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_kind  <= '0;
      err_unit  <= '0;
    end else begin
      busy    <= (state != S_IDLE);
      p_valid <= 1'b0;
      p_last  <= 1'b0;

      if (wr_fire) begin
        grid[wr_ptr] <= wr_data;
        done         <= 1'b0;
        if (wr_ptr == ADDR_W'(CELLS - 1)) begin
          wr_ptr    <= '0;
          grid_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start_fire) begin
            state    <= S_ROWS;
            unit_cnt <= '0;
            cell_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_kind <= '0;
            err_unit <= '0;
          end
        end
        default: begin
          p_valid <= 1'b1;
          p_val   <= grid[rd_addr];
          p_first <= (cell_cnt == '0);
          p_kind  <= state;
          p_unit  <= unit_cnt;
          p_last  <= (state == S_BOXES) && unit_end && unit_last;
          if (unit_end) begin
            cell_cnt <= '0;
            if (unit_last) begin
              unit_cnt <= '0;
              case (state)
                S_ROWS:  state <= S_COLS;
                S_COLS:  state <= S_BOXES;
                default: state <= S_IDLE;
              endcase
            end else begin
              unit_cnt <= unit_cnt + IDX_W'(1);
            end
          end else begin
            cell_cnt <= cell_cnt + IDX_W'(1);
          end
        end
      endcase

      if (p_valid) begin
        seen <= seen_next;
        if (cell_bad) begin
          err <= 1'b1;
          // First violation wins; later ones only keep err set.
          if (!err) begin
            err_kind <= p_kind;
            err_unit <= p_unit;
          end
        end
        if (p_last) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_grid_checker.sv
module tb_sudoku_grid_checker;

  localparam int BW   = 3;
  localparam int N    = BW * BW;
  localparam int NN   = N * N;
  localparam int SCAN = 3 * NN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;

  // Main instance (ALLOW_EMPTY=1) and a sibling (ALLOW_EMPTY=0) on the same stimulus.
  logic       wr_ready, grid_full, busy, done, err;
  logic [1:0] err_kind;
  logic [3:0] err_unit;
  logic       b_wr_ready, b_grid_full, b_busy, b_done, b_err;
  logic [1:0] b_err_kind;
  logic [3:0] b_err_unit;

  // 4x4 instance with its own stimulus.
  logic       c_clr = 1'b0, c_wr_valid = 1'b0, c_start = 1'b0;
  logic [2:0] c_wr_data = '0;
  logic       c_wr_ready, c_grid_full, c_busy, c_done, c_err;
  logic [1:0] c_err_kind;
  logic [1:0] c_err_unit;

  sudoku_grid_checker #(.BOX_W(3), .ALLOW_EMPTY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .grid_full(grid_full), .start(start), .busy(busy),
    .done(done), .err(err), .err_kind(err_kind), .err_unit(err_unit));

  sudoku_grid_checker #(.BOX_W(3), .ALLOW_EMPTY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(b_wr_ready), .grid_full(b_grid_full), .start(start), .busy(b_busy),
    .done(b_done), .err(b_err), .err_kind(b_err_kind), .err_unit(b_err_unit));

  sudoku_grid_checker #(.BOX_W(2), .ALLOW_EMPTY(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .wr_valid(c_wr_valid), .wr_data(c_wr_data),
    .wr_ready(c_wr_ready), .grid_full(c_grid_full), .start(c_start), .busy(c_busy),
    .done(c_done), .err(c_err), .err_kind(c_err_kind), .err_unit(c_err_unit));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (BOX_W=3 instances) ----------------
  int m_grid[NN];
  int m_ptr;
  bit m_full;
  bit m_done;
  int m_cnt;       // edges since start was taken; -1 when idle
  bit m_idle;
  bit m_err[2];    // [0] empty allowed, [1] empty forbidden
  int m_kind[2];
  int m_unit[2];

  task automatic model_reset();
    foreach (m_grid[i]) m_grid[i] = 0;
    m_ptr  = 0;
    m_full = 0;
    m_done = 0;
    m_cnt  = -1;
    for (int j = 0; j < 2; j++) begin
      m_err[j]  = 0;
      m_kind[j] = 0;
      m_unit[j] = 0;
    end
  endtask

  // A unit is bad if any member breaks the rules, wherever it sits.
  function automatic bit unit_bad(int kind, int u, bit allow);
    int cells[$];
    bit seen[N+1];
    for (int i = 0; i <= N; i++) seen[i] = 0;
    case (kind)
      1:       for (int c = 0; c < N; c++) cells.push_back(m_grid[u*N + c]);
      2:       for (int r = 0; r < N; r++) cells.push_back(m_grid[r*N + u]);
      default: for (int dr = 0; dr < BW; dr++)
                 for (int dc = 0; dc < BW; dc++)
                   cells.push_back(m_grid[((u/BW)*BW + dr)*N + (u%BW)*BW + dc]);
    endcase
    foreach (cells[i]) begin
      if (cells[i] == 0) begin
        if (!allow) return 1;
      end else if (cells[i] > N) return 1;
      else if (seen[cells[i]]) return 1;
      else seen[cells[i]] = 1;
    end
    return 0;
  endfunction

  task automatic eval_grid(input bit allow, output bit e, output int k, output int u);
    e = 0; k = 0; u = 0;
    for (int kind = 1; kind <= 3; kind++)
      for (int uu = 0; uu < N; uu++)
        if (!e && unit_bad(kind, uu, allow)) begin
          e = 1; k = kind; u = uu;
        end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      m_idle = (m_cnt < 0);
      if (m_cnt >= 0) begin
        m_cnt++;
        if (m_cnt == SCAN + 1) begin
          m_cnt  = -1;
          m_done = 1;
          eval_grid(1'b1, m_err[0], m_kind[0], m_unit[0]);
          eval_grid(1'b0, m_err[1], m_kind[1], m_unit[1]);
        end
      end
      if (m_idle && wr_valid) begin
        m_grid[m_ptr] = int'(wr_data);
        m_done = 0;
        if (m_ptr == NN - 1) begin
          m_ptr  = 0;
          m_full = 1;
        end else m_ptr++;
      end
      if (m_idle && start) begin
        m_cnt  = 0;
        m_done = 0;
        for (int j = 0; j < 2; j++) begin
          m_err[j] = 0; m_kind[j] = 0; m_unit[j] = 0;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",      busy,      (m_cnt >= 1 && m_cnt <= SCAN));
      check("b_busy",    b_busy,    (m_cnt >= 1 && m_cnt <= SCAN));
      check("wr_ready",  wr_ready,  (m_cnt < 0));
      check("done",      done,      m_done);
      check("b_done",    b_done,    m_done);
      check("grid_full", grid_full, m_full);
      if (m_cnt < 0) begin
        check("err",   err,   m_err[0]);
        check("b_err", b_err, m_err[1]);
      end
      if (m_done || m_cnt == 0) begin
        check("err_kind",   err_kind,   m_kind[0]);
        check("err_unit",   err_unit,   m_unit[0]);
        check("b_err_kind", b_err_kind, m_kind[1]);
        check("b_err_unit", b_err_unit, m_unit[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int stim[NN];

  task automatic fill_solved();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        stim[r*N + c] = ((r*BW + r/BW + c) % N) + 1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load_stim();
    for (int i = 0; i < NN; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(stim[i]);
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  // Start now; count edges to done and busy observations. Optionally drive
  // writes for 5 cycles mid-scan (they must be dropped).
  task automatic run_scan(input string tag, input int write_at);
    int e, nbusy;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wr_valid = 1'b0;
    e = 0;
    nbusy = 0;
    while (!done && e < 400) begin
      @(negedge clk);
      e++;
      if (busy) nbusy++;
      wr_valid = (write_at >= 0 && e >= write_at && e < write_at + 5);
      wr_data  = 4'd7;
    end
    wr_valid = 1'b0;
    check({tag, "_latency"}, e, SCAN + 1);
    check({tag, "_busy_cycles"}, nbusy, SCAN);
  endtask

  initial begin
    int e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_kind", err_kind, 0);
    check("rst_unit", err_unit, 0);
    check("rst_full", grid_full, 0);
    check("rst_ready", wr_ready, 1);

    // 4x4 valid grid: done 49 edges after the start edge.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        c_wr_valid = 1'b1;
        c_wr_data  = 3'(((r*2 + r/2 + c) % 4) + 1);
        @(negedge clk);
      end
    c_wr_valid = 1'b0;
    check("c_full", c_grid_full, 1);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    e = 0;
    while (!c_done && e < 100) begin
      @(negedge clk);
      e++;
    end
    check("c_latency", e, 49);
    check("c_err", c_err, 0);
    check("c_kind", c_err_kind, 0);

    // All-zero grid straight out of reset.
    run_scan("zero", -1);
    check("zero_err", err, 0);
    check("zero_b_err", b_err, 1);
    check("zero_b_kind", b_err_kind, 1);
    check("zero_b_unit", b_err_unit, 0);

    // Solved grid, with writes attempted mid-scan; rescan proves they were dropped.
    fill_solved();
    pulse_clr();
    load_stim();
    run_scan("solved", 20);
    check("solved_err", err, 0);
    check("solved_kind", err_kind, 0);
    check("solved_b_err", b_err, 0);
    run_scan("rescan", -1);
    check("rescan_err", err, 0);

    // Row duplicate: (4,7) takes the value of (4,2).
    fill_solved();
    stim[4*N + 7] = stim[4*N + 2];
    pulse_clr();
    load_stim();
    run_scan("rowdup", -1);
    check("rowdup_err", err, 1);
    check("rowdup_kind", err_kind, 1);
    check("rowdup_unit", err_unit, 4);
    check("model_rowdup_unit", m_unit[0], 4);

    // Columns 0 and 1 swapped in row 0 only.
    fill_solved();
    e = stim[0]; stim[0] = stim[1]; stim[1] = e;
    pulse_clr();
    load_stim();
    run_scan("colswap", -1);
    check("colswap_err", err, 1);
    check("colswap_kind", err_kind, 2);
    check("colswap_unit", err_unit, 0);
    check("model_colswap_kind", m_kind[0], 2);

    // Start at scan cycle 50 ignored, clr at cycle 100 aborts.
    fill_solved();
    pulse_clr();
    load_stim();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = (i == 50);
      clr   = (i == 100);
    end
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_err", err, 0);
    check("clr_full", grid_full, 0);

    // 81 writes set grid_full; an 82nd write lands in cell 0 after the wrap.
    load_stim();
    check("wrap_full", grid_full, 1);
    wr_valid = 1'b1;
    wr_data  = 4'd10;
    @(negedge clk);
    wr_valid = 1'b0;
    run_scan("wrap", -1);
    check("wrap_err", err, 1);
    check("wrap_kind", err_kind, 1);
    check("wrap_unit", err_unit, 0);
    check("wrap_b_kind", b_err_kind, 1);

    // Write and start in the same idle cycle: the scan sees the new value.
    fill_solved();
    pulse_clr();
    load_stim();
    wr_valid = 1'b1;
    wr_data  = 4'd5;
    run_scan("wrstart", -1);
    check("wrstart_err", err, 1);
    check("wrstart_kind", err_kind, 1);
    check("wrstart_unit", err_unit, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
